axi_regfile_burst: RTL and testbench

//  Parametrised AXI3 slave register file for the PS master GP port, successor to axi_regs.

---
 rtl/axi_regfile_burst.sv | 235 +++++++++++++++++++++++
 tb/tb_axi_regfile_burst.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_regfile_burst.sv
// AXI3 slave register file with INCR/FIXED bursts, byte strobes, ID echo, per-register
// write pulses, read-only status words and SLVERR reporting on illegal size/burst or WLAST misuse.
module axi_regfile_burst #(
    parameter int               NREGS    = 16,
    parameter int               ADDR_LSB = 2,
    parameter logic [NREGS-1:0] RO_MASK  = '0,
    parameter logic [31:0]      RST_VAL  = 32'h0
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [31:0]          ARADDR,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    input  logic [11:0]          ARID,
    input  logic [3:0]           ARLEN,
    input  logic [1:0]           ARSIZE,
    input  logic [1:0]           ARBURST,
    input  logic [31:0]          AWADDR,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [11:0]          AWID,
    input  logic [3:0]           AWLEN,
    input  logic [1:0]           AWSIZE,
    input  logic [1:0]           AWBURST,
    input  logic [11:0]          WID,
    input  logic [31:0]          WDATA,
    input  logic [3:0]           WSTRB,
    input  logic                 WVALID,
    input  logic                 WLAST,
    output logic                 WREADY,
    output logic                 BVALID,
    input  logic                 BREADY,
    output logic [11:0]          BID,
    output logic [1:0]           BRESP,
    output logic [31:0]          RDATA,
    output logic                 RVALID,
    input  logic                 RREADY,
    output logic [11:0]          RID,
    output logic                 RLAST,
    output logic [1:0]           RRESP,
    output logic [NREGS*32-1:0]  regs_out,
    input  logic [NREGS*32-1:0]  status_in,
    output logic [NREGS-1:0]     wr_pulse
);
    localparam int             IW      = $clog2(NREGS);
    localparam logic [IW-1:0]  IDX_ONE = 1;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t        w_state_r, w_next_s;
    r_state_t        r_state_r, r_next_s;
    logic [31:0]     regs_r [NREGS];
    logic [NREGS-1:0] wr_pulse_r;

    logic            awready_r, wready_r, bvalid_r;
    logic [11:0]     bid_r;
    logic [1:0]      bresp_r;
    logic [IW-1:0]   w_idx_r;
    logic [3:0]      w_len_r, w_cnt_r;
    logic            w_err_r, w_lerr_r, w_fixed_r;

    logic            arready_r, rvalid_r, rlast_r;
    logic [31:0]     rdata_r;
    logic [11:0]     rid_r;
    logic [1:0]      rresp_r;
    logic [IW-1:0]   r_idx_r, r_next_idx_s;
    logic [3:0]      r_len_r, r_cnt_r;
    logic            r_fixed_r;

    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic w_final_s, r_final_s, aw_err_s, ar_err_s;
    logic [IW-1:0] aw_idx_s, ar_idx_s;
    logic unused_s;

    assign aw_hs_s   = AWVALID && awready_r;
    assign w_hs_s    = WVALID && wready_r;
    assign b_hs_s    = bvalid_r && BREADY;
    assign ar_hs_s   = ARVALID && arready_r;
    assign r_hs_s    = rvalid_r && RREADY;
    assign w_final_s = (w_cnt_r == w_len_r);
    assign r_final_s = (r_cnt_r == r_len_r);
    // WRAP and any size other than one full word are rejected with SLVERR
    assign aw_err_s  = (AWSIZE != 2'b10) || AWBURST[1];
    assign ar_err_s  = (ARSIZE != 2'b10) || ARBURST[1];
    assign aw_idx_s  = AWADDR[ADDR_LSB +: IW];
    assign ar_idx_s  = ARADDR[ADDR_LSB +: IW];
    assign r_next_idx_s = r_fixed_r ? r_idx_r : r_idx_r + IDX_ONE;
    assign unused_s  = ^{WID, AWADDR, ARADDR};

    assign AWREADY  = awready_r;
    assign WREADY   = wready_r;
    assign BVALID   = bvalid_r;
    assign BID      = bid_r;
    assign BRESP    = bresp_r;
    assign ARREADY  = arready_r;
    assign RVALID   = rvalid_r;
    assign RDATA    = rdata_r;
    assign RID      = rid_r;
    assign RLAST    = rlast_r;
    assign RRESP    = rresp_r;
    assign wr_pulse = wr_pulse_r;

    function automatic logic [31:0] rd_word(input logic [IW-1:0] i);
        if (RO_MASK[i]) rd_word = status_in[32*i +: 32];
        else            rd_word = regs_r[i];
    endfunction

    // Flat register image; read-only slots are exported as zero
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_out[32*i +: 32] = RO_MASK[i] ? 32'h0 : regs_r[i];
        end
    end

    // Write FSM next state
    always_comb begin
        w_next_s = w_state_r;
        case (w_state_r)
            W_IDLE:  if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
            W_DATA:  if (w_hs_s && w_final_s) w_next_s = W_RESP; else w_next_s = W_DATA;
            W_RESP:  if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
            default: w_next_s = W_IDLE;
        endcase
    end

    // Write FSM state, handshake outputs and burst bookkeeping
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= 12'h0;
            bresp_r   <= 2'b00;
            w_idx_r   <= '0;
            w_len_r   <= 4'd0;
            w_cnt_r   <= 4'd0;
            w_err_r   <= 1'b0;
            w_lerr_r  <= 1'b0;
            w_fixed_r <= 1'b0;
        end else begin
            w_state_r <= w_next_s;
            awready_r <= (w_next_s == W_IDLE);
            wready_r  <= (w_next_s == W_DATA);
            bvalid_r  <= (w_next_s == W_RESP);
            if (aw_hs_s) begin
                w_idx_r   <= aw_idx_s;
                w_len_r   <= AWLEN;
                w_cnt_r   <= 4'd0;
                bid_r     <= AWID;
                w_err_r   <= aw_err_s;
                w_lerr_r  <= 1'b0;
                w_fixed_r <= (AWBURST == 2'b00) && !aw_err_s;
            end
            if (w_hs_s) begin
                w_cnt_r <= w_cnt_r + 4'd1;
                if (!w_fixed_r) w_idx_r <= w_idx_r + IDX_ONE;
                // WLAST is only checked, the beat count alone ends the burst
                if (WLAST != w_final_s) w_lerr_r <= 1'b1;
                if (w_final_s) begin
                    bresp_r <= (w_err_r || w_lerr_r || (WLAST != w_final_s)) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    // Register storage with byte strobes and one-cycle update pulses
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NREGS; i++) regs_r[i] <= RST_VAL;
            wr_pulse_r <= '0;
        end else begin
            wr_pulse_r <= '0;
            if (w_hs_s && !w_err_r && !RO_MASK[w_idx_r]) begin
                for (int b = 0; b < 4; b++) begin
                    if (WSTRB[b]) regs_r[w_idx_r][8*b +: 8] <= WDATA[8*b +: 8];
                end
                wr_pulse_r[w_idx_r] <= 1'b1;
            end
        end
    end

    // Read FSM next state
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE:  if (ar_hs_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
            R_DATA:  if (r_hs_s && r_final_s) r_next_s = R_IDLE; else r_next_s = R_DATA;
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read FSM state and registered R channel; next beat preloads on each handshake
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rdata_r   <= 32'h0;
            rid_r     <= 12'h0;
            rresp_r   <= 2'b00;
            r_idx_r   <= '0;
            r_len_r   <= 4'd0;
            r_cnt_r   <= 4'd0;
            r_fixed_r <= 1'b0;
        end else begin
            r_state_r <= r_next_s;
            arready_r <= (r_next_s == R_IDLE);
            if (ar_hs_s) begin
                r_idx_r   <= ar_idx_s;
                r_len_r   <= ARLEN;
                r_cnt_r   <= 4'd0;
                rid_r     <= ARID;
                r_fixed_r <= (ARBURST == 2'b00) && !ar_err_s;
                rresp_r   <= ar_err_s ? 2'b10 : 2'b00;
                rvalid_r  <= 1'b1;
                rlast_r   <= (ARLEN == 4'd0);
                rdata_r   <= rd_word(ar_idx_s);
            end else if (r_hs_s) begin
                if (r_final_s) begin
                    rvalid_r <= 1'b0;
                    rlast_r  <= 1'b0;
                end else begin
                    r_idx_r <= r_next_idx_s;
                    r_cnt_r <= r_cnt_r + 4'd1;
                    rlast_r <= ((r_cnt_r + 4'd1) == r_len_r);
                    rdata_r <= rd_word(r_next_idx_s);
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_regfile_burst.sv
// Directed bench for axi_regfile_burst: single and burst writes/reads, strobes, RO slots,
// error responses, read stalls, read/write collision and mid-burst reset.
module tb_axi_regfile_burst;
    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [31:0]  ARADDR, AWADDR, WDATA, RDATA;
    logic         ARVALID, ARREADY, AWVALID, AWREADY;
    logic [11:0]  ARID, AWID, WID, RID, BID;
    logic [3:0]   ARLEN, AWLEN, WSTRB;
    logic [1:0]   ARSIZE, AWSIZE, ARBURST, AWBURST, RRESP, BRESP;
    logic         RVALID, BVALID, RREADY, BREADY, RLAST, WVALID, WLAST, WREADY;
    logic [511:0] regs_out, status_in;
    logic [15:0]  wr_pulse;
    int           n_cmp = 0;
    int           n_err = 0;
    logic [31:0]  exp5 [3];

    always #5 ACLK = ~ACLK;

    axi_regfile_burst #(.NREGS(16), .ADDR_LSB(2), .RO_MASK(16'h1000), .RST_VAL(32'h0)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RLAST(RLAST), .RRESP(RRESP),
        .regs_out(regs_out), .status_in(status_in), .wr_pulse(wr_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return regs_out[32*i +: 32];
    endfunction

    task automatic aw_send(input logic [31:0] a, input logic [11:0] id, input logic [3:0] len,
                           input logic [1:0] size, input logic [1:0] burst);
        int n = 0;
        AWADDR = a; AWID = id; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        while (AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
        check("awready", 32'(AWREADY), 32'h1);
        tick();
        AWVALID = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [11:0] id, input logic [3:0] len,
                           input logic [1:0] size, input logic [1:0] burst);
        int n = 0;
        ARADDR = a; ARID = id; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && n < 50) begin tick(); n++; end
        check("arready", 32'(ARREADY), 32'h1);
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        WDATA = d; WSTRB = s; WLAST = l; WVALID = 1'b1;
        while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
        check("wready", 32'(WREADY), 32'h1);
        tick();
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic b_recv(input string tag, input logic [1:0] resp, input logic [11:0] id);
        int n = 0;
        BREADY = 1'b1;
        while (BVALID !== 1'b1 && n < 50) begin tick(); n++; end
        check({tag, "_bvalid"}, 32'(BVALID), 32'h1);
        check({tag, "_bresp"}, 32'(BRESP), 32'(resp));
        check({tag, "_bid"}, 32'(BID), 32'(id));
        tick();
        BREADY = 1'b0;
    endtask

    task automatic r_recv(input string tag, input logic [31:0] d, input logic l,
                          input logic [1:0] resp, input logic [11:0] id);
        int n = 0;
        RREADY = 1'b1;
        while (RVALID !== 1'b1 && n < 50) begin tick(); n++; end
        check({tag, "_rdata"}, RDATA, d);
        check({tag, "_rlast"}, 32'(RLAST), 32'(l));
        check({tag, "_rresp"}, 32'(RRESP), 32'(resp));
        check({tag, "_rid"}, 32'(RID), 32'(id));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ARESETN = 1'b0;
        ARADDR = 32'h0; ARVALID = 1'b0; ARID = 12'h0; ARLEN = 4'd0; ARSIZE = 2'b10; ARBURST = 2'b01;
        AWADDR = 32'h0; AWVALID = 1'b0; AWID = 12'h0; AWLEN = 4'd0; AWSIZE = 2'b10; AWBURST = 2'b01;
        WID = 12'h0; WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0; WLAST = 1'b0;
        RREADY = 1'b0; BREADY = 1'b0;
        status_in = '0;
        status_in[32*12 +: 32] = 32'hC0DE_0012;
        exp5[0] = 32'h1; exp5[1] = 32'h2; exp5[2] = 32'h3;

        // reset state
        tick(); tick();
        check("rst_awready", 32'(AWREADY), 32'h0);
        check("rst_arready", 32'(ARREADY), 32'h0);
        check("rst_wready", 32'(WREADY), 32'h0);
        check("rst_bvalid", 32'(BVALID), 32'h0);
        check("rst_rvalid", 32'(RVALID), 32'h0);
        check("rst_rlast", 32'(RLAST), 32'h0);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_pulse", 32'(wr_pulse), 32'h0);
        for (int i = 0; i < 16; i++) check("rst_reg", reg_of(i), 32'h0);
        ARESETN = 1'b1;
        tick();
        check("rel_awready", 32'(AWREADY), 32'h1);
        check("rel_arready", 32'(ARREADY), 32'h1);

        // 1: single write and read back at 0x08
        aw_send(32'h08, 12'h0A1, 4'd0, 2'b10, 2'b01);
        w_beat(32'hA5A5_1234, 4'hF, 1'b1);
        check("t1_pulse", 32'(wr_pulse), 32'h0004);
        tick();
        check("t1_pulse_off", 32'(wr_pulse), 32'h0);
        b_recv("t1", 2'b00, 12'h0A1);
        check("t1_reg2", reg_of(2), 32'hA5A5_1234);
        ar_send(32'h08, 12'h0B2, 4'd0, 2'b10, 2'b01);
        r_recv("t1r", 32'hA5A5_1234, 1'b1, 2'b00, 12'h0B2);
        RREADY = 1'b0;

        // 2: INCR burst wrapping 14,15,0,1
        aw_send(32'h38, 12'h003, 4'd3, 2'b10, 2'b01);
        w_beat(32'h1, 4'hF, 1'b0);
        w_beat(32'h2, 4'hF, 1'b0);
        w_beat(32'h3, 4'hF, 1'b0);
        w_beat(32'h4, 4'hF, 1'b1);
        b_recv("t2", 2'b00, 12'h003);
        check("t2_reg14", reg_of(14), 32'h1);
        check("t2_reg15", reg_of(15), 32'h2);
        check("t2_reg0", reg_of(0), 32'h3);
        check("t2_reg1", reg_of(1), 32'h4);
        ar_send(32'h38, 12'h004, 4'd3, 2'b10, 2'b01);
        r_recv("t2r1", 32'h1, 1'b0, 2'b00, 12'h004);
        check("t2_b2b2", 32'(RVALID), 32'h1);
        r_recv("t2r2", 32'h2, 1'b0, 2'b00, 12'h004);
        check("t2_b2b3", 32'(RVALID), 32'h1);
        r_recv("t2r3", 32'h3, 1'b0, 2'b00, 12'h004);
        check("t2_b2b4", 32'(RVALID), 32'h1);
        r_recv("t2r4", 32'h4, 1'b1, 2'b00, 12'h004);
        RREADY = 1'b0;
        check("t2_rdone", 32'(RVALID), 32'h0);

        // 3: byte strobe, RO write drop, RO read of status
        aw_send(32'h14, 12'h005, 4'd0, 2'b10, 2'b01);
        w_beat(32'hFFFF_FFFF, 4'b0100, 1'b1);
        b_recv("t3", 2'b00, 12'h005);
        check("t3_reg5", reg_of(5), 32'h00FF_0000);
        aw_send(32'h30, 12'h006, 4'd0, 2'b10, 2'b01);
        w_beat(32'h1234_5678, 4'hF, 1'b1);
        check("t3_ro_pulse", 32'(wr_pulse), 32'h0);
        b_recv("t3ro", 2'b00, 12'h006);
        check("t3_reg12", reg_of(12), 32'h0);
        ar_send(32'h30, 12'h007, 4'd0, 2'b10, 2'b01);
        r_recv("t3r", 32'hC0DE_0012, 1'b1, 2'b00, 12'h007);
        RREADY = 1'b0;
        status_in[32*12 +: 32] = 32'h5555_AAAA;
        ar_send(32'h30, 12'h008, 4'd0, 2'b10, 2'b01);
        r_recv("t3r2", 32'h5555_AAAA, 1'b1, 2'b00, 12'h008);
        RREADY = 1'b0;

        // 4: illegal size, WRAP, misplaced WLAST
        aw_send(32'h18, 12'h010, 4'd1, 2'b01, 2'b01);
        w_beat(32'hDEAD_0001, 4'hF, 1'b0);
        w_beat(32'hDEAD_0002, 4'hF, 1'b1);
        check("t4_size_pulse", 32'(wr_pulse), 32'h0);
        b_recv("t4size", 2'b10, 12'h010);
        check("t4_reg6a", reg_of(6), 32'h0);
        aw_send(32'h18, 12'h011, 4'd0, 2'b10, 2'b10);
        w_beat(32'hDEAD_0003, 4'hF, 1'b1);
        b_recv("t4wrap", 2'b10, 12'h011);
        check("t4_reg6b", reg_of(6), 32'h0);
        aw_send(32'h1C, 12'h012, 4'd3, 2'b10, 2'b01);
        w_beat(32'h11, 4'hF, 1'b0);
        w_beat(32'h22, 4'hF, 1'b1);
        check("t4_still_data", 32'(BVALID), 32'h0);
        w_beat(32'h33, 4'hF, 1'b0);
        w_beat(32'h44, 4'hF, 1'b1);
        b_recv("t4wlast", 2'b10, 12'h012);

        // 5: read with RREADY toggling over regs 14,15,0
        ar_send(32'h38, 12'h020, 4'd2, 2'b10, 2'b01);
        for (int k = 0; k < 3; k++) begin
            RREADY = 1'b0;
            tick();
            check("t5_rvalid", 32'(RVALID), 32'h1);
            check("t5_rdata", RDATA, exp5[k]);
            check("t5_rlast", 32'(RLAST), (k == 2) ? 32'h1 : 32'h0);
            RREADY = 1'b1;
            tick();
        end
        RREADY = 1'b0;
        check("t5_rdone", 32'(RVALID), 32'h0);
        check("t5_arready", 32'(ARREADY), 32'h1);

        // 5b: read and write of reg 8 on the same edge returns the old value
        aw_send(32'h20, 12'h021, 4'd0, 2'b10, 2'b01);
        w_beat(32'h1111_0008, 4'hF, 1'b1);
        b_recv("t5pre", 2'b00, 12'h021);
        aw_send(32'h20, 12'h022, 4'd0, 2'b10, 2'b01);
        ARADDR = 32'h20; ARID = 12'h023; ARLEN = 4'd0; ARSIZE = 2'b10; ARBURST = 2'b01; ARVALID = 1'b1;
        WDATA = 32'h7777_7777; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
        check("t5_col_ar", 32'(ARREADY), 32'h1);
        check("t5_col_w", 32'(WREADY), 32'h1);
        tick();
        ARVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
        r_recv("t5col", 32'h1111_0008, 1'b1, 2'b00, 12'h023);
        RREADY = 1'b0;
        b_recv("t5col", 2'b00, 12'h022);
        check("t5_reg8", reg_of(8), 32'h7777_7777);

        // 6: reset in the middle of a write burst
        aw_send(32'h24, 12'h030, 4'd3, 2'b10, 2'b01);
        w_beat(32'hAAAA_AAAA, 4'hF, 1'b0);
        ARESETN = 1'b0;
        #1;
        check("t6_awready", 32'(AWREADY), 32'h0);
        check("t6_wready", 32'(WREADY), 32'h0);
        check("t6_bvalid", 32'(BVALID), 32'h0);
        check("t6_arready", 32'(ARREADY), 32'h0);
        check("t6_pulse", 32'(wr_pulse), 32'h0);
        check("t6_reg2", reg_of(2), 32'h0);
        check("t6_reg9", reg_of(9), 32'h0);
        check("t6_reg14", reg_of(14), 32'h0);
        tick(); tick();
        ARESETN = 1'b1;
        tick();
        check("t6_bvalid2", 32'(BVALID), 32'h0);
        check("t6_awready2", 32'(AWREADY), 32'h1);
        aw_send(32'h24, 12'h031, 4'd0, 2'b10, 2'b01);
        w_beat(32'h0000_600D, 4'hF, 1'b1);
        b_recv("t6", 2'b00, 12'h031);
        ar_send(32'h24, 12'h032, 4'd0, 2'b10, 2'b01);
        r_recv("t6r", 32'h0000_600D, 1'b1, 2'b00, 12'h032);
        RREADY = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
